qupls_mem_issue_queue: RTL and testbench

//  Buffers memory-op ROB indices emitted by the memory scheduler (up to two per cycle, ndx0 older than
//  ndx1) and presents them one at a time, in order, to the load/store unit over a valid/ready handshake.

---
 rtl/qupls_mem_issue_queue.sv | 142 ++++++++++++++
 tb/tb_qupls_mem_issue_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qupls_mem_issue_queue.sv
// In-order issue queue between the memory scheduler and the LSU request port.
// Accepts up to two ROB indices per cycle, issues one per cycle, drains stomped entries.
module qupls_mem_issue_queue #(
  parameter int unsigned QDEPTH      = 8,
  parameter int unsigned ROB_ENTRIES = 32,
  parameter int unsigned NDX_W       = $clog2(ROB_ENTRIES),
  parameter int unsigned CNT_W       = $clog2(QDEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NDX_W-1:0]       ndx0_i,
  input  logic                   ndx0v_i,
  input  logic                   ndx0_store_i,
  input  logic [NDX_W-1:0]       ndx1_i,
  input  logic                   ndx1v_i,
  input  logic                   ndx1_store_i,
  input  logic [ROB_ENTRIES-1:0] robentry_stomp_i,
  output logic                   q_full_o,
  output logic                   mem_req_v_o,
  output logic [NDX_W-1:0]       mem_req_ndx_o,
  output logic                   mem_req_store_o,
  input  logic                   mem_req_rdy_i,
  output logic [CNT_W-1:0]       q_count_o,
  output logic                   q_overflow_o
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);

  logic             live_q  [QDEPTH];
  logic             live_d  [QDEPTH];
  logic [NDX_W-1:0] ndx_q   [QDEPTH];
  logic [NDX_W-1:0] ndx_d   [QDEPTH];
  logic             store_q [QDEPTH];
  logic             store_d [QDEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             overflow_q, overflow_d;

  logic             not_empty;
  logic             head_live;
  logic             head_stomp;
  logic             deq;
  logic [1:0]       enq_cnt;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] offs;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        live_q[i]  <= 1'b0;
        ndx_q[i]   <= '0;
        store_q[i] <= 1'b0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        live_q[i]  <= live_d[i];
        ndx_q[i]   <= ndx_d[i];
        store_q[i] <= store_d[i];
      end
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state and head-request logic
  always_comb begin
    live_d     = live_q;
    ndx_d      = ndx_q;
    store_d    = store_q;
    head_d     = head_q;
    tail_d     = tail_q;
    overflow_d = overflow_q;
    enq_cnt    = 2'd0;
    wptr       = tail_q;
    offs       = '0;

    not_empty  = (count_q != '0);
    head_live  = live_q[head_q];
    head_stomp = robentry_stomp_i[ndx_q[head_q]];

    // A stomp on the head kills the request in the same cycle
    mem_req_v_o     = not_empty & head_live & ~head_stomp;
    mem_req_ndx_o   = not_empty ? ndx_q[head_q] : '0;
    mem_req_store_o = not_empty & store_q[head_q];

    deq = not_empty & ((mem_req_v_o & mem_req_rdy_i) | ~head_live | head_stomp);

    for (int i = 0; i < QDEPTH; i++) begin
      offs = PTR_W'(i) - head_q;
      if ((CNT_W'(offs) < count_q) && robentry_stomp_i[ndx_q[i]]) begin
        live_d[i] = 1'b0;
      end
    end

    if (deq) begin
      live_d[head_q] = 1'b0;
      head_d         = head_q + PTR_W'(1);
    end

    // Full is registered, so the free slots written here are never occupied or being dequeued
    if (ndx0v_i | ndx1v_i) begin
      if (full_q) begin
        overflow_d = 1'b1;
      end else begin
        if (ndx0v_i) begin
          live_d[wptr]  = ~robentry_stomp_i[ndx0_i];
          ndx_d[wptr]   = ndx0_i;
          store_d[wptr] = ndx0_store_i;
          wptr          = wptr + PTR_W'(1);
        end
        if (ndx1v_i) begin
          live_d[wptr]  = ~robentry_stomp_i[ndx1_i];
          ndx_d[wptr]   = ndx1_i;
          store_d[wptr] = ndx1_store_i;
          wptr          = wptr + PTR_W'(1);
        end
        tail_d  = wptr;
        enq_cnt = 2'(ndx0v_i) + 2'(ndx1v_i);
      end
    end

    count_d = count_q + CNT_W'(enq_cnt) - CNT_W'(deq);
    full_d  = (count_d >= CNT_W'(QDEPTH - 1));
  end

  assign q_full_o     = full_q;
  assign q_count_o    = count_q;
  assign q_overflow_o = overflow_q;

endmodule

// File: tb/tb_qupls_mem_issue_queue.sv
// Randomised self-checking bench for qupls_mem_issue_queue against a queue-based reference model.
module tb_qupls_mem_issue_queue;

  localparam int unsigned QDEPTH = 8;
  localparam int unsigned ROB    = 32;
  localparam int unsigned NW     = 5;
  localparam int unsigned CW     = 4;
  localparam int unsigned VW     = 1 + NW + 1 + CW + 1 + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NW-1:0] ndx0, ndx1;
  logic          ndx0v, ndx1v, ndx0_store, ndx1_store;
  logic [ROB-1:0] stomp;
  logic          rdy;
  logic          q_full, req_v, req_store, q_ovf;
  logic [NW-1:0] req_ndx;
  logic [CW-1:0] q_count;

  int checks = 0;
  int errors = 0;

  qupls_mem_issue_queue #(.QDEPTH(QDEPTH), .ROB_ENTRIES(ROB)) dut (
    .clk(clk), .rst_n(rst_n),
    .ndx0_i(ndx0), .ndx0v_i(ndx0v), .ndx0_store_i(ndx0_store),
    .ndx1_i(ndx1), .ndx1v_i(ndx1v), .ndx1_store_i(ndx1_store),
    .robentry_stomp_i(stomp),
    .q_full_o(q_full), .mem_req_v_o(req_v), .mem_req_ndx_o(req_ndx),
    .mem_req_store_o(req_store), .mem_req_rdy_i(rdy),
    .q_count_o(q_count), .q_overflow_o(q_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NW-1:0] ndx;
    logic          st;
    logic          live;
  } ent_t;

  ent_t          mq[$];
  bit            m_ovf;
  logic [NW:0]   iss_exp[$];
  logic [NW:0]   iss_dut[$];

  function automatic bit m_full();
    return (int'(QDEPTH) - int'(mq.size())) < 2;
  endfunction

  function automatic bit m_v();
    return mq.size() != 0 && mq[0].live && !stomp[mq[0].ndx];
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [NW-1:0] n;
    logic          s;
    n = (mq.size() != 0) ? mq[0].ndx : '0;
    s = (mq.size() != 0) ? mq[0].st : 1'b0;
    return {m_v(), n, s, CW'(mq.size()), m_full(), m_ovf};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {req_v, req_ndx, req_store, q_count, q_full, q_ovf};
  endfunction

  // Reference model advances on each clock edge using the inputs held across it
  task automatic model_step();
    bit v, full, deq;
    ent_t e;
    v    = m_v();
    full = m_full();
    deq  = mq.size() != 0 && ((v && rdy) || !mq[0].live || stomp[mq[0].ndx]);
    if (v && rdy) iss_exp.push_back({mq[0].st, mq[0].ndx});
    foreach (mq[i]) if (stomp[mq[i].ndx]) mq[i].live = 1'b0;
    if (deq) void'(mq.pop_front());
    if (ndx0v || ndx1v) begin
      if (full) m_ovf = 1'b1;
      else begin
        if (ndx0v) begin e.ndx = ndx0; e.st = ndx0_store; e.live = !stomp[ndx0]; mq.push_back(e); end
        if (ndx1v) begin e.ndx = ndx1; e.st = ndx1_store; e.live = !stomp[ndx1]; mq.push_back(e); end
      end
    end
  endtask

  always @(posedge clk) if (rst_n) model_step();

  task automatic step(input logic a0v, input logic [NW-1:0] a0, input logic a0s,
                      input logic a1v, input logic [NW-1:0] a1, input logic a1s,
                      input logic [ROB-1:0] st, input logic r);
    @(negedge clk);
    ndx0v = a0v; ndx0 = a0; ndx0_store = a0s;
    ndx1v = a1v; ndx1 = a1; ndx1_store = a1s;
    stomp = st; rdy = r;
    #1;
    if (req_v === 1'b1 && rdy) iss_dut.push_back({req_store, req_ndx});
  endtask

  task automatic idle(input logic r);
    step(0, '0, 0, 0, '0, 0, '0, r);
  endtask

  task automatic test_reset();
    ndx0v = 0; ndx1v = 0; ndx0 = '0; ndx1 = '0; ndx0_store = 0; ndx1_store = 0;
    stomp = '0; rdy = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    mq.delete(); m_ovf = 0; iss_exp.delete(); iss_dut.delete();
    #1;
    checks++;
    if (obs_vec() !== '0) begin
      errors++; $display("FAIL reset_state got=%h want=0", obs_vec());
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_pair();
    logic [NW:0] want[$];
    step(1, 5, 0, 1, 9, 1, '0, 1);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL pair_cyc%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      idle(1);
    end
    want = '{6'h05, 6'h29};
    checks++;
    if (iss_dut != want) begin
      errors++; $display("FAIL pair_order got=%p want=%p", iss_dut, want);
    end
  endtask

  task automatic test_full();
    step(1, 1, 0, 0, '0, 0, '0, 0);
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL full_fill%0d got=%h want=%h", p, obs_vec(), exp_vec());
      end
      step(1, NW'(2 * p + 2), 1, 1, NW'(2 * p + 3), 0, '0, 0);
    end
    idle(0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL full_after got=%h want=%h", obs_vec(), exp_vec());
    end
    checks++;
    if ({q_count, q_full, q_ovf} !== {CW'(7), 1'b1, 1'b1}) begin
      errors++; $display("FAIL full_overflow got cnt=%0d full=%b ovf=%b want 7 1 1", q_count, q_full, q_ovf);
    end
  endtask

  task automatic test_stomp_drain();
    logic [NW:0] want[$];
    iss_dut.delete(); iss_exp.delete();
    step(1, 3, 0, 1, 4, 1, '0, 0);
    step(1, 6, 1, 0, '0, 0, '0, 0);
    step(0, '0, 0, 0, '0, 0, ROB'(1) << 4, 1);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL stomp_cyc%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      idle(1);
    end
    want = '{6'h03, 6'h26};
    checks++;
    if (iss_dut != want) begin
      errors++; $display("FAIL stomp_order got=%p want=%p", iss_dut, want);
    end
  endtask

  task automatic test_head_stomp();
    step(1, 12, 1, 0, '0, 0, '0, 0);
    idle(0);
    checks++;
    if ({req_v, req_ndx} !== {1'b1, NW'(12)}) begin
      errors++; $display("FAIL hstomp_pre got v=%b ndx=%0d want 1 12", req_v, req_ndx);
    end
    step(0, '0, 0, 0, '0, 0, ROB'(1) << 12, 0);
    checks++;
    if (req_v !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL hstomp_same got=%h want=%h", obs_vec(), exp_vec());
    end
    idle(0);
    checks++;
    if (q_count !== '0 || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL hstomp_drain got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    int sent = 0;
    int c;
    logic a0v, a1v;
    logic [ROB-1:0] st;
    iss_dut.delete(); iss_exp.delete();
    for (c = 0; c < 600 && !(sent >= 3 * QDEPTH && mq.size() == 0); c++) begin
      a0v = 0; a1v = 0;
      if (sent < 3 * QDEPTH && !m_full()) begin
        a0v = 1'($urandom_range(1));
        a1v = (sent + int'(a0v) < 3 * QDEPTH) ? 1'($urandom_range(1)) : 1'b0;
      end
      sent += int'(a0v) + int'(a1v);
      st = ($urandom_range(15) == 0) ? (ROB'(1) << $urandom_range(ROB - 1)) : '0;
      step(a0v, NW'($urandom), 1'($urandom), a1v, NW'($urandom), 1'($urandom), st,
           1'($urandom_range(1)));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rand_cyc%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (mq.size() != 0 || sent < 3 * QDEPTH) begin
      errors++; $display("FAIL rand_timeout got sent=%0d left=%0d want all drained", sent, mq.size());
    end
    idle(0);
    checks++;
    if (iss_dut != iss_exp) begin
      errors++; $display("FAIL rand_order got=%p want=%p", iss_dut, iss_exp);
    end
  endtask

  task automatic test_reset_mid();
    step(1, 1, 0, 1, 2, 1, '0, 0);
    step(1, 3, 1, 1, 4, 0, '0, 0);
    step(1, 5, 0, 0, '0, 0, '0, 0);
    idle(0);
    checks++;
    if (q_count !== CW'(5) || obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL rmid_pre got=%h want=%h", obs_vec(), exp_vec());
    end
    rdy = 1;
    #2 rst_n = 1'b0;
    mq.delete(); m_ovf = 0;
    #1;
    checks++;
    if (obs_vec() !== '0) begin
      errors++; $display("FAIL rmid_async got=%h want=0", obs_vec());
    end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      idle(1);
      checks++;
      if (req_v !== 1'b0 || obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rmid_post%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_full();
    test_reset();
    test_stomp_drain();
    test_head_stomp();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
